data_ram_arbiter: RTL
=====================

Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters:
  - port 0: CPU control unit (load/store).
  - port 1: program/data loader (DMA-style, used for preloading and debug readback).
- Sits between the requesters and the RAM's address/wdata/mem_wr/mem_rd/rd_data pins.
- Sequences each access through a fixed-length strobe window.
- Returns a one-cycle acknowledge with registered read data.
- Arbitration is round-robin, so neither requester starves.

Parameters:
ADDR_W, 32, address width (matches ALU result / RAM address)
DATA_W, 32, data width
ACCESS_CYCLES, 1, cycles mem_rd/mem_wr held per access; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  CPU access request; held until ack0
we0  in  1  CPU write enable (1 = write, 0 = read)
addr0  in  ADDR_W  CPU address
wdata0  in  DATA_W  CPU write data
ack0  out  1  one-cycle pulse: CPU access complete
req1  in  1  loader access request; held until ack1
we1  in  1  loader write enable
addr1  in  ADDR_W  loader address
wdata1  in  DATA_W  loader write data
ack1  out  1  one-cycle pulse: loader access complete
rdata  out  DATA_W  read data of completed access; valid with ack0/ack1
busy  out  1  high in ACCESS and DONE
owner  out  1  requester currently/last served (0 = CPU, 1 = loader)
address  out  ADDR_W  to RAM address
wdata  out  DATA_W  to RAM wdata
mem_wr  out  1  RAM write strobe
mem_rd  out  1  RAM read strobe
rd_data  in  DATA_W  from RAM, combinational read

Behaviour:
- Output rules:
  - All outputs are registered.
  - Reset values: ack0 = ack1 = 0, rdata = 0, busy = 0, owner = 0, address = 0, wdata = 0, mem_wr = 0, mem_rd = 0.
  - The last-served pointer resets to 1, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay.
  - Exactly one req high: select it.
  - Both high: select the requester that was not last served.
  - On selection, at the edge:
    - latch addr and wdata into address/wdata, and we into an internal register;
    - set owner;
    - load cnt = ACCESS_CYCLES-1;
    - go to ACCESS.
- ACCESS:
  - mem_wr = latched we; mem_rd = !latched we.
  - The two strobes are never both high.
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - when reading, capture rd_data into rdata;
    - drop both strobes;
    - assert ack of owner;
    - update last-served = owner;
    - go to DONE.
  - address/wdata remain stable for the whole ACCESS window.
- DONE:
  - ack of owner is high for exactly this one cycle.
  - rdata is held until the next read completes; a write does not change rdata.
  - Next edge: go to IDLE, ack low.
- Latency:
  - req sampled high at edge T → strobes high for cycles T+1 .. T+ACCESS_CYCLES.
  - ack high in cycle T+ACCESS_CYCLES+1.
  - ACCESS_CYCLES=1 gives a 3-cycle turnaround per access (IDLE, ACCESS, DONE).
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees ack.
  - Requester drops req at the edge ending the ack cycle. Because the FSM passes through IDLE, a requester that drops req this way is never double-served.
  - A req still high in IDLE after ack is a new access.
- Request withdrawn mid-access: the access completes and ack still pulses. There is no abort.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1…
- Reset mid-operation:
  - At the reset edge the FSM goes to IDLE and all outputs take reset values; strobes are low in the next cycle.
  - No ack is issued for the aborted access.
  - A write interrupted by reset may or may not have landed in RAM; software must re-issue it.
- Parameter guard: ACCESS_CYCLES outside 1..15 is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared include of constants:
  - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2;
  - requester IDs REQ_CPU = 1'b0, REQ_LDR = 1'b1.
- One natural sub-module, rr_pick2: combinational 2-way round-robin select.
  - Inputs: req0, req1, last.
  - Outputs: grant_valid, grant_id.
  - The FSM, counter and datapath registers stay in data_ram_arbiter.

Test Plan:
- CPU write only:
  - Stimulus: ACCESS_CYCLES=1; req0, we0=1, addr0=0x10, wdata0=0xDEADBEEF.
  - Required: mem_wr high exactly 1 cycle with address=0x10, wdata=0xDEADBEEF; ack0 two cycles after the sampling edge; ack1 never high.
- Loader read with stretched access:
  - Stimulus: ACCESS_CYCLES=3; RAM model holds 0x12345678 at 0x20; req1, we1=0, addr1=0x20.
  - Required: mem_rd high exactly 3 cycles; ack1 pulse 1 cycle; rdata=0x12345678 during ack1 and held afterwards.
- Simultaneous requests from reset:
  - Stimulus: req0 and req1 asserted in the same cycle.
  - Required: CPU served first (owner=0, ack0); loader served next (owner=1, ack1); both held high for 4 accesses → ack order 0,1,0,1.
- Withdrawal mid-access:
  - Stimulus: req0 dropped during ACCESS.
  - Required: access completes; ack0 still pulses; FSM returns to IDLE with no second access.
- Reset mid-access:
  - Stimulus: ACCESS_CYCLES=4; rst asserted on the 2nd strobe cycle.
  - Required: mem_wr/mem_rd low next cycle; busy=0; no ack; the next access after reset is arbitrated CPU-first.
- Back-to-back single requester:
  - Stimulus: req0 re-asserted immediately after each ack0, 3 accesses.
  - Required: each access starts via IDLE; mem_rd/mem_wr never high in the DONE or IDLE cycles; never both high.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants for the data RAM arbiter: FSM encodings, requester IDs
// and the width of the access-window counter.
package data_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    // Wide enough for ACCESS_CYCLES-1 with ACCESS_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/data_ram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin select: a lone requester wins outright,
// a tie goes to whichever requester was not served last.
module data_ram_arbiter_rr_pick2
    import data_ram_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last;
        end else if (req1) begin
            grant_id = REQ_LDR;
        end else begin
            grant_id = REQ_CPU;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares one single-port data RAM between the CPU (port 0) and the loader
// (port 1) with round-robin arbitration and a fixed-length strobe window.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              owner,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] rd_data
);

    generate
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cfg
            $error("data_ram_arbiter: ACCESS_CYCLES=%0d is outside 1..15", ACCESS_CYCLES);
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                we_lat, we_lat_next;
    logic                last, last_next;
    logic                grant_valid, grant_id;

    logic                ack0_next, ack1_next, busy_next, owner_next;
    logic                mem_wr_next, mem_rd_next;
    logic [DATA_W-1:0]   rdata_next, wdata_next;
    logic [ADDR_W-1:0]   address_next;
    logic                sel_we;

    data_ram_arbiter_rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Handshake: a requester raises req with we/addr/wdata and holds them
    // until it sees its one-cycle ack, then drops req at the edge ending the
    // ack cycle. req is only sampled in IDLE, so a req still high after DONE
    // is a fresh access and a dropped req is never served twice.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        we_lat_next  = we_lat;
        last_next    = last;
        ack0_next    = 1'b0;
        ack1_next    = 1'b0;
        busy_next    = busy;
        owner_next   = owner;
        rdata_next   = rdata;
        address_next = address;
        wdata_next   = wdata;
        mem_wr_next  = mem_wr;
        mem_rd_next  = mem_rd;
        sel_we       = (grant_id == REQ_LDR) ? we1 : we0;

        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next   = ST_ACCESS;
                    owner_next   = grant_id;
                    we_lat_next  = sel_we;
                    address_next = (grant_id == REQ_LDR) ? addr1 : addr0;
                    wdata_next   = (grant_id == REQ_LDR) ? wdata1 : wdata0;
                    cnt_next     = CNT_LOAD;
                    busy_next    = 1'b1;
                    mem_wr_next  = sel_we;
                    mem_rd_next  = ~sel_we;
                end
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    // rd_data is combinational on the held address, so it is
                    // settled by the final strobe cycle.
                    if (!we_lat) begin
                        rdata_next = rd_data;
                    end
                    mem_wr_next = 1'b0;
                    mem_rd_next = 1'b0;
                    ack0_next   = (owner == REQ_CPU);
                    ack1_next   = (owner == REQ_LDR);
                    last_next   = owner;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                busy_next   = 1'b0;
                mem_wr_next = 1'b0;
                mem_rd_next = 1'b0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_lat  <= 1'b0;
            last    <= REQ_LDR;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            busy    <= 1'b0;
            owner   <= REQ_CPU;
            rdata   <= '0;
            address <= '0;
            wdata   <= '0;
            mem_wr  <= 1'b0;
            mem_rd  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            we_lat  <= we_lat_next;
            last    <= last_next;
            ack0    <= ack0_next;
            ack1    <= ack1_next;
            busy    <= busy_next;
            owner   <= owner_next;
            rdata   <= rdata_next;
            address <= address_next;
            wdata   <= wdata_next;
            mem_wr  <= mem_wr_next;
            mem_rd  <= mem_rd_next;
        end
    end

endmodule
